crossbar_slave_mem: RTL

//  Responder (slave) end of the crossbar req/cmd/addr/wdata/rdata/ack interface.

---
 rtl/crossbar_slave_mem.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/crossbar_slave_mem.sv
// crossbar_slave_mem: responder end of the crossbar req/ack interface.
// Models a word-addressed 32-bit memory with a fixed number of wait states per access.
// Optional feature macro: CROSSBAR_SLAVE_RAND_WAIT_EN. When it is defined, an LFSR
// chooses the wait states for each access instead of WAIT_CYCLES.
module crossbar_slave_mem #(
    parameter int unsigned AW          = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slave_req,
    input  logic        slave_cmd,
    input  logic [31:0] slave_addr,
    input  logic [31:0] slave_wdata,
    output logic [31:0] slave_rdata,
    output logic        slave_ack,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [CW-1:0]  wait_load;
    logic           accept;

    logic           cmd_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [31:0]    mem [DEPTH];

    // Byte-lane bits and the bits above the word index alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{slave_addr[31:AW+2], slave_addr[1:0]};

`ifdef CROSSBAR_SLAVE_RAND_WAIT_EN
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;

    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign wait_load = lfsr[3:0];

    // Fibonacci LFSR (taps 8,6,5,4) that advances once for each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign wait_load = CW'(WAIT_CYCLES);
`endif

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. The IDLE cycle after ACK carries slave_ack=1, so acceptance is blocked there.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (slave_req && !slave_ack) begin
                    accept = 1'b1;
                    if (wait_load == '0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_load - CW'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request fields on acceptance. Later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cmd_q   <= slave_cmd;
            idx_q   <= slave_addr[AW+1:2];
            wdata_q <= slave_wdata;
        end
    end

    // Memory array. Writes commit on the edge that leaves ACK, so a reset in WAIT or ACK drops them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (state == ACK && cmd_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Registered outputs. ack and rdata change on the edge that leaves ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            slave_ack   <= 1'b0;
            busy        <= 1'b0;
            slave_rdata <= '0;
        end else begin
            slave_ack <= (state == ACK);
            busy      <= (state_next != IDLE);
            if (state == ACK && !cmd_q) begin
                slave_rdata <= mem[idx_q];
            end
        end
    end

endmodule
